// File: rtl/slave_bus_arbiter.sv
// slave_bus_arbiter
// Round-robin arbiter and sequencer that shares one slave register port
// (slave_addr/rd/wr/data_in/data_out) among NUM_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> [WAIT] -> DONE -> IDLE.
// Optional feature: define ARB_LOCK_EN to add the req_lock input, which
// lets a requester keep ownership of the port across back-to-back grants.
module slave_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rd,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     req_lock,
`endif
    output logic [NUM_REQ-1:0]     ack,
    output logic [31:0]            rdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [31:0]            slave_addr,
    output logic                   slave_rd,
    output logic                   slave_wr,
    output logic [31:0]            slave_data_in,
    input  logic [31:0]            slave_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of requester (base + k) wrapped into 0..NUM_REQ-1
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Unpacked views of the packed per-requester buses
    logic [31:0] addr_arr  [NUM_REQ];
    logic [31:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[32*gi +: 32];
            assign wdata_arr[gi] = req_wdata[32*gi +: 32];
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   op_rd_q, op_rd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   slave_rd_q, slave_rd_d;
    logic                   slave_wr_q, slave_wr_d;
    logic [31:0]            slave_addr_q, slave_addr_d;
    logic [31:0]            slave_data_in_q, slave_data_in_d;
    logic [31:0]            rdata_q, rdata_d;

    logic                   rr_found;
    logic [IDX_W-1:0]       rr_idx;
    logic [IDX_W-1:0]       rr_base;
    logic                   lock_hold;
    logic                   sel_valid;
    logic [IDX_W-1:0]       sel_idx;

`ifdef ARB_LOCK_EN
    logic                   lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]       lock_owner_q, lock_owner_d;

    // Lock owner keeps winning while it still requests and still asserts its lock;
    // once released, the round-robin search restarts just after the lock owner.
    assign lock_hold = lock_valid_q && req[lock_owner_q] && req_lock[lock_owner_q];
    assign rr_base   = lock_valid_q ? lock_owner_q : last_grant_q;
    assign sel_idx   = lock_hold ? lock_owner_q : rr_idx;
`else
    assign lock_hold = 1'b0;
    assign rr_base   = last_grant_q;
    assign sel_idx   = rr_idx;
`endif

    assign sel_valid = lock_hold | rr_found;

    // Round-robin search: first set req bit after rr_base, wrapping around
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req[wrap_idx(rr_base, k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_idx(rr_base, k);
            end
        end
    end

    // Next-state and next-output computation for the transaction sequencer
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        op_rd_d         = op_rd_q;
        cnt_d           = cnt_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        ack_d           = '0;
        busy_d          = busy_q;
        slave_rd_d      = 1'b0;
        slave_wr_d      = 1'b0;
        slave_addr_d    = slave_addr_q;
        slave_data_in_d = slave_data_in_q;
        rdata_d         = rdata_q;
`ifdef ARB_LOCK_EN
        lock_valid_d    = lock_valid_q;
        lock_owner_d    = lock_owner_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef ARB_LOCK_EN
                if (!lock_hold) lock_valid_d = 1'b0;
`endif
                if (sel_valid) begin
                    state_d         = ISSUE;
                    idx_d           = sel_idx;
                    op_rd_d         = req_rd[sel_idx];
                    grant_d         = onehot(sel_idx);
                    busy_d          = 1'b1;
                    // Strobe registers load here so they are high during ISSUE only;
                    // read wins when both op bits are set.
                    slave_rd_d      = req_rd[sel_idx];
                    slave_wr_d      = req_wr[sel_idx] & ~req_rd[sel_idx];
                    slave_addr_d    = addr_arr[sel_idx];
                    slave_data_in_d = wdata_arr[sel_idx];
                    if (!lock_hold) last_grant_d = sel_idx;
                end
            end

            ISSUE: begin
                if (op_rd_q) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                end else begin
                    state_d = DONE;
                    ack_d   = onehot(idx_q);
                end
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    rdata_d = slave_data_out;
                    ack_d   = onehot(idx_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
`ifdef ARB_LOCK_EN
                if (req_lock[idx_q]) begin
                    lock_valid_d = 1'b1;
                    lock_owner_d = idx_q;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight transaction at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            op_rd_q         <= 1'b0;
            cnt_q           <= '0;
            last_grant_q    <= IDX_W'(NUM_REQ - 1);
            grant_q         <= '0;
            ack_q           <= '0;
            busy_q          <= 1'b0;
            slave_rd_q      <= 1'b0;
            slave_wr_q      <= 1'b0;
            slave_addr_q    <= '0;
            slave_data_in_q <= '0;
            rdata_q         <= '0;
`ifdef ARB_LOCK_EN
            lock_valid_q    <= 1'b0;
            lock_owner_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            op_rd_q         <= op_rd_d;
            cnt_q           <= cnt_d;
            last_grant_q    <= last_grant_d;
            grant_q         <= grant_d;
            ack_q           <= ack_d;
            busy_q          <= busy_d;
            slave_rd_q      <= slave_rd_d;
            slave_wr_q      <= slave_wr_d;
            slave_addr_q    <= slave_addr_d;
            slave_data_in_q <= slave_data_in_d;
            rdata_q         <= rdata_d;
`ifdef ARB_LOCK_EN
            lock_valid_q    <= lock_valid_d;
            lock_owner_q    <= lock_owner_d;
`endif
        end
    end

    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign slave_addr    = slave_addr_q;
    assign slave_rd      = slave_rd_q;
    assign slave_wr      = slave_wr_q;
    assign slave_data_in = slave_data_in_q;

endmodule

// File: tb/tb_slave_bus_arbiter.sv
// tb_slave_bus_arbiter
// Scoreboard bench: expected slave strobes and acks (with their cycle numbers)
// are queued when stimulus is driven and popped by a negedge monitor.
// A small slave model returns read data exactly RD_LATENCY cycles after the
// strobe cycle and garbage at all other times.
module tb_slave_bus_arbiter;

    localparam int N = 4;
    localparam int L = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req, req_rd, req_wr;
    logic [N*32-1:0]   req_addr, req_wdata;
`ifdef ARB_LOCK_EN
    logic [N-1:0]      req_lock;
`endif
    logic [N-1:0]      ack, grant;
    logic [31:0]       rdata, slave_addr, slave_data_in, slave_data_out;
    logic              busy, slave_rd, slave_wr;

    slave_bus_arbiter #(.NUM_REQ(N), .RD_LATENCY(L)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_rd         (req_rd),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
`ifdef ARB_LOCK_EN
        .req_lock       (req_lock),
`endif
        .ack            (ack),
        .rdata          (rdata),
        .grant          (grant),
        .busy           (busy),
        .slave_addr     (slave_addr),
        .slave_rd       (slave_rd),
        .slave_wr       (slave_wr),
        .slave_data_in  (slave_data_in),
        .slave_data_out (slave_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic [N-1:0] vec;
        logic [31:0]  rdata;
        int           cyc;
    } ack_t;

    strobe_t     sq[$];
    ack_t        aq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_func(input logic [31:0] a);
        if (a == 32'h4) return 32'h1234_5678;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Slave model: data valid only RD_LATENCY cycles after the strobe cycle
    logic        rd_pipe [L+1];
    logic [31:0] a_pipe  [L+1];
    always @(negedge clk) begin
        for (int j = L; j > 0; j--) begin
            rd_pipe[j] = rd_pipe[j-1];
            a_pipe[j]  = a_pipe[j-1];
        end
        rd_pipe[0] = slave_rd;
        a_pipe[0]  = slave_addr;
        slave_data_out = rd_pipe[L] ? rd_func(a_pipe[L]) : 32'hBAD0_BAD0;
    end

    // Monitor: compare every strobe and ack against the scoreboard queues
    always @(negedge clk) begin
        strobe_t s;
        ack_t    a;
        if (!reset) begin
            if (slave_rd || slave_wr) begin
                check("strobe_excl", 64'(slave_rd & slave_wr), 64'd0);
                if (sq.size() == 0) begin
                    check("strobe_unexpected", 64'd1, 64'd0);
                end else begin
                    s = sq.pop_front();
                    check("strobe_rd",   64'(slave_rd),      64'(s.rd));
                    check("strobe_wr",   64'(slave_wr),      64'(s.wr));
                    check("strobe_addr", 64'(slave_addr),    64'(s.addr));
                    if (s.wr) check("strobe_wdata", 64'(slave_data_in), 64'(s.data));
                    check("strobe_cycle", 64'(cyc), 64'(s.cyc));
                end
            end
            if (ack != '0) begin
                if (aq.size() == 0) begin
                    check("ack_unexpected", 64'(ack), 64'd0);
                end else begin
                    a = aq.pop_front();
                    check("ack_vec",    64'(ack),   64'(a.vec));
                    check("ack_rdata",  64'(rdata), 64'(a.rdata));
                    check("ack_cycle",  64'(cyc),   64'(a.cyc));
                    check("ack_grant",  64'(grant), 64'(a.vec));
                end
            end
        end
    end

    task automatic clear_inputs();
        req       = '0;
        req_rd    = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd);
        req[i]             = 1'b1;
        req_rd[i]          = rd;
        req_wr[i]          = wr;
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wd;
    endtask

    // Queue the expected strobe/ack of a transaction sampled in cycle c0
    task automatic expect_txn(input int i, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd, input int c0);
        strobe_t s;
        ack_t    a;
        if (rd || wr) begin
            s.rd = rd; s.wr = wr & ~rd; s.addr = addr; s.data = wd; s.cyc = c0 + 1;
            sq.push_back(s);
        end
        if (rd) exp_rdata = rd_func(addr);
        a.vec = oh(i); a.rdata = exp_rdata; a.cyc = c0 + 2 + (rd ? L : 0);
        aq.push_back(a);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    // One transaction; req drops one cycle after the grant (must not matter)
    task automatic send_one(input int i, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd);
        int c0;
        @(negedge clk);
        clear_inputs();
        set_req(i, rd, wr, addr, wd);
        c0 = cyc;
        expect_txn(i, rd, wr, addr, wd, c0);
        @(negedge clk);
        check("grant_issue", 64'(grant), 64'(oh(i)));
        check("busy_issue",  64'(busy),  64'd1);
        clear_inputs();
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    64'(ack),           64'd0);
        check({tag, "_grant"},  64'(grant),         64'd0);
        check({tag, "_busy"},   64'(busy),          64'd0);
        check({tag, "_rd"},     64'(slave_rd),      64'd0);
        check({tag, "_wr"},     64'(slave_wr),      64'd0);
        check({tag, "_addr"},   64'(slave_addr),    64'd0);
        check({tag, "_wdata"},  64'(slave_data_in), 64'd0);
        check({tag, "_rdata"},  64'(rdata),         64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        strobe_t s;
        reset = 1'b1;
        clear_inputs();
`ifdef ARB_LOCK_EN
        req_lock = '0;
`endif
        for (int j = 0; j <= L; j++) begin
            rd_pipe[j] = 1'b0;
            a_pipe[j]  = '0;
        end
        slave_data_out = 32'hBAD0_BAD0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single write, single read, rd+wr precedence, no-op
        send_one(2, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        send_one(1, 1'b1, 1'b0, 32'h4,  32'h0);
        send_one(0, 1'b1, 1'b1, 32'h20, 32'h1111_2222);
        send_one(3, 1'b0, 1'b0, 32'h40, 32'h5555_AAAA);
        send_one(2, 1'b1, 1'b0, 32'h88, 32'h0);

        // Contention: all four requesters write, held; order 0,1,2,3,0 (last_grant=2 -> 3 first?)
        // last_grant is 2 after the read above, so the order here is 3,0,1,2,3.
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 32'h100 + i, 32'hA000_0000 + i);
        for (int n = 0; n < 5; n++) begin
            int i;
            i = (3 + n) % N;
            expect_txn(i, 1'b0, 1'b1, 32'h100 + i, 32'hA000_0000 + i, c0 + 3*n);
        end
        repeat (13) @(negedge clk);
        clear_inputs();
        wait_idle();

        // Contention after a fresh reset: requester 0 wins first
        do_reset();
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 32'h200 + i, 32'hB000_0000 + i);
        for (int n = 0; n < 5; n++) begin
            expect_txn(n % N, 1'b0, 1'b1, 32'h200 + (n % N), 32'hB000_0000 + (n % N), c0 + 3*n);
        end
        repeat (13) @(negedge clk);
        clear_inputs();
        wait_idle();

        // Reset asserted during WAIT: immediate abort, no ack
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
        c0 = cyc;
        s.rd = 1'b1; s.wr = 1'b0; s.addr = 32'h8; s.data = '0; s.cyc = c0 + 1;
        sq.push_back(s);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = '0;
        send_one(3, 1'b0, 1'b1, 32'h30, 32'hCAFE_F00D);
        send_one(1, 1'b1, 1'b0, 32'h4, 32'h0);

`ifdef ARB_LOCK_EN
        // Lock: requester 1 keeps the port until its lock drops, then 0 is next
        do_reset();
        @(negedge clk);
        c0 = cyc;
        set_req(0, 1'b0, 1'b1, 32'h300, 32'hC000_0000);
        set_req(1, 1'b0, 1'b1, 32'h301, 32'hC000_0001);
        req_lock = 4'b0010;
        expect_txn(0, 1'b0, 1'b1, 32'h300, 32'hC000_0000, c0);
        expect_txn(1, 1'b0, 1'b1, 32'h301, 32'hC000_0001, c0 + 3);
        expect_txn(1, 1'b0, 1'b1, 32'h301, 32'hC000_0001, c0 + 6);
        expect_txn(1, 1'b0, 1'b1, 32'h301, 32'hC000_0001, c0 + 9);
        expect_txn(0, 1'b0, 1'b1, 32'h300, 32'hC000_0000, c0 + 12);
        repeat (11) @(negedge clk);
        req_lock = '0;
        repeat (2) @(negedge clk);
        clear_inputs();
        wait_idle();
`endif

        repeat (4) @(negedge clk);
        check("strobes_pending", 64'(sq.size()), 64'd0);
        check("acks_pending",    64'(aq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
